// File: rtl/stream_buf_pkg.sv
// Shared helpers for the stream buffer family: pointer width and parameter checks.
package stream_buf_pkg;

  // One extra pointer bit distinguishes full from empty when the addresses match.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/ring_buf_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
// Kept separate so the array can be remapped to LUTRAM/BRAM without touching control.
module ring_buf_mem #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_ring_buf.sv
// AXI-Stream elastic ring buffer with registered tready/tvalid, tlast sideband,
// occupancy level, almost-full/almost-empty flags and synchronous flush.
module axis_ring_buf
  import stream_buf_pkg::*;
#(
  parameter int DWIDTH        = 32,
  parameter int DEPTH         = 4,
  parameter int AFULL_THRESH  = DEPTH - 1,
  parameter int AEMPTY_THRESH = 1,
  localparam int PW           = ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [DWIDTH-1:0] s_axis_tdata,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DWIDTH-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [PW-1:0]     level,
  output logic              almost_full,
  output logic              almost_empty
);

  localparam int AW = PW - 1;

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("axis_ring_buf: DEPTH must be a power of two >= 2");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
    $error("axis_ring_buf: AFULL_THRESH out of range 1..DEPTH");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
    $error("axis_ring_buf: AEMPTY_THRESH out of range 0..DEPTH-1");
  end

  typedef struct packed {
    logic              last;
    logic [DWIDTH-1:0] data;
  } entry_t;

  logic [PW-1:0] wr_ptr, rd_ptr, nlevel;
  logic          wr_fire, rd_fire;
  entry_t        wr_entry, rd_entry;

  // A handshake coinciding with flush is consumed by the flush and dropped.
  assign wr_fire = s_axis_tvalid && s_axis_tready && !flush;
  assign rd_fire = m_axis_tvalid && m_axis_tready && !flush;

  assign level  = wr_ptr - rd_ptr;
  assign nlevel = level + PW'(wr_fire) - PW'(rd_fire);

  assign wr_entry = '{last: s_axis_tlast, data: s_axis_tdata};

  ring_buf_mem #(
    .WIDTH($bits(entry_t)),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (wr_fire),
    .waddr(wr_ptr[AW-1:0]),
    .wdata(wr_entry),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(rd_entry)
  );

  assign m_axis_tdata = rd_entry.data;
  assign m_axis_tlast = rd_entry.last;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      s_axis_tready <= 1'b1;
      m_axis_tvalid <= 1'b0;
    end else begin
      wr_ptr        <= wr_ptr + PW'(wr_fire);
      rd_ptr        <= rd_ptr + PW'(rd_fire);
      s_axis_tready <= (nlevel != PW'(DEPTH));
      m_axis_tvalid <= (nlevel != '0);
    end
  end

  assign almost_full  = (level >= PW'(AFULL_THRESH));
  assign almost_empty = (level <= PW'(AEMPTY_THRESH));

endmodule

// File: tb/tb_axis_ring_buf.sv
// Randomised scoreboard bench for axis_ring_buf against a queue-based model of a FIFO.
module tb_axis_ring_buf;

  localparam int DWIDTH = 32;
  localparam int DEPTH  = 4;
  localparam int AFULL  = 3;
  localparam int AEMPTY = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic [DWIDTH-1:0] s_axis_tdata = '0;
  logic              s_axis_tlast = 1'b0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tready;
  logic [DWIDTH-1:0] m_axis_tdata;
  logic              m_axis_tlast;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b0;
  logic [2:0]        level;
  logic              almost_full, almost_empty;

  axis_ring_buf #(
    .DWIDTH(DWIDTH), .DEPTH(DEPTH), .AFULL_THRESH(AFULL), .AEMPTY_THRESH(AEMPTY)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .level(level), .almost_full(almost_full), .almost_empty(almost_empty)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int wr_cnt  = 0;
  int rd_cnt  = 0;
  int cyc     = 0;
  logic [DWIDTH:0] model_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor/scoreboard: the model is just an ordered queue of accepted beats.
  always @(negedge clk) begin
    int exp_lvl;
    if (rst) begin
      model_q.delete();
    end else begin
      exp_lvl = model_q.size();
      chk("level", 64'(level), 64'(exp_lvl));
      chk("m_tvalid", 64'(m_axis_tvalid), 64'(exp_lvl != 0));
      chk("s_tready", 64'(s_axis_tready), 64'(exp_lvl != DEPTH));
      chk("almost_full", 64'(almost_full), 64'(exp_lvl >= AFULL));
      chk("almost_empty", 64'(almost_empty), 64'(exp_lvl <= AEMPTY));
      if (m_axis_tvalid && exp_lvl != 0)
        chk("m_head", 64'({m_axis_tlast, m_axis_tdata}), 64'(model_q[0]));
      if (flush) begin
        model_q.delete();
      end else begin
        if (m_axis_tvalid && m_axis_tready) begin
          chk("read_has_model_beat", 64'(model_q.size() != 0), 64'(1));
          if (model_q.size() != 0) void'(model_q.pop_front());
          rd_cnt++;
        end
        if (s_axis_tvalid && s_axis_tready) begin
          model_q.push_back({s_axis_tlast, s_axis_tdata});
          wr_cnt++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [DWIDTH-1:0] d, input logic l);
    bit done = 1'b0;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      done = s_axis_tready && !flush;
      step();
    end
    if (!done) begin
      n_total++;
      $display("FAIL push_timeout: beat %0h not accepted within 200 cycles", d);
    end
  endtask

  task automatic drain();
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    for (int n = 0; n < 500 && model_q.size() != 0; n++) step();
    chk("drain_empty", 64'(model_q.size()), 64'(0));
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0, rd0, c0;
    bit rnd_done;

    // Reset and idle
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'(0));
    chk("rst_s_tready", 64'(s_axis_tready), 64'(1));
    chk("rst_level", 64'(level), 64'(0));
    chk("rst_almost_empty", 64'(almost_empty), 64'(1));
    chk("rst_almost_full", 64'(almost_full), 64'(0));
    step();

    // Fill with downstream stalled
    m_axis_tready = 1'b0;
    for (int i = 0; i < 4; i++) push_beat(32'hA0 + 32'(i), 1'b0);
    wr0 = wr_cnt;
    s_axis_tdata = 32'hA4; s_axis_tlast = 1'b1; s_axis_tvalid = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("a4_held", 64'(wr_cnt - wr0), 64'(0));
    chk("full_level", 64'(level), 64'(4));
    chk("full_tready", 64'(s_axis_tready), 64'(0));
    step();

    // Drain from full; A4 must follow A0..A3
    m_axis_tready = 1'b1;
    push_beat(32'hA4, 1'b1);
    drain();
    chk("fill_drain_count", 64'(rd_cnt), 64'(5));

    // Streaming across pointer wrap
    m_axis_tready = 1'b1;
    c0 = cyc; rd0 = rd_cnt;
    for (int i = 0; i < 20; i++) push_beat(32'(i), (i == 7) || (i == 19));
    chk("stream_accept_cycles", 64'(cyc - c0), 64'(20));
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    #1;
    chk("stream_delivered", 64'(rd_cnt - rd0), 64'(20));
    drain();

    // Random traffic on both sides
    rnd_done = 1'b0;
    wr0 = wr_cnt;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          while ($urandom_range(1, 0) == 1) begin
            s_axis_tvalid = 1'b0;
            step();
          end
          push_beat($urandom, $urandom_range(7, 0) == 0);
        end
        s_axis_tvalid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          m_axis_tready = $urandom_range(1, 0) == 1;
          step();
        end
      end
    join
    drain();
    chk("random_accepted", 64'(wr_cnt - wr0), 64'(1000));
    chk("random_balance", 64'(wr_cnt - rd_cnt), 64'(0));

    // Flush at level 3 with coincident write and read
    m_axis_tready = 1'b0;
    for (int i = 0; i < 3; i++) push_beat(32'h10 + 32'(i), 1'b0);
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    chk("preflush_level", 64'(level), 64'(3));
    step();
    s_axis_tdata = 32'hFF; s_axis_tlast = 1'b1; s_axis_tvalid = 1'b1;
    m_axis_tready = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
    @(negedge clk);
    chk("flush_level", 64'(level), 64'(0));
    chk("flush_m_tvalid", 64'(m_axis_tvalid), 64'(0));
    chk("flush_s_tready", 64'(s_axis_tready), 64'(1));
    step();
    rd0 = rd_cnt;
    m_axis_tready = 1'b1;
    push_beat(32'h55, 1'b1);
    drain();
    chk("post_flush_delivered", 64'(rd_cnt - rd0), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axis_ring_buf.md
Name: axis_ring_buf

Overview:
- Parametrised-depth AXI-Stream elastic buffer: a circular buffer of DEPTH entries with registered handshake outputs.
- Generalises the two-entry ping-pong buffer used between packer stages.
- Adds a tlast sideband, a fill level output, almost-full/almost-empty flags and a synchronous flush.
- Sits between packer pipeline stages wherever more than two beats of slack are needed to absorb downstream back-pressure.

Parameters:
- DWIDTH, 32, tdata width in bits (>=1).
- DEPTH, 4, number of entries; power of two, >=2. Elaboration error otherwise.
- AFULL_THRESH, DEPTH-1, almost_full asserts when level >= AFULL_THRESH (1..DEPTH).
- AEMPTY_THRESH, 1, almost_empty asserts when level <= AEMPTY_THRESH (0..DEPTH-1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous discard of all buffered beats
- s_axis_tdata  in  DWIDTH  input data
- s_axis_tlast  in  1  input end-of-packet
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready (registered)
- m_axis_tdata  out  DWIDTH  output data
- m_axis_tlast  out  1  output end-of-packet
- m_axis_tvalid  out  1  output valid (registered)
- m_axis_tready  in  1  output ready
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- almost_full  out  1  level >= AFULL_THRESH
- almost_empty  out  1  level <= AEMPTY_THRESH

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - Pointers = 0, level = 0, m_axis_tvalid = 0, s_axis_tready = 1.
  - almost_full = (AFULL_THRESH==0, never true), almost_empty = 1.
  - Memory contents are not reset.
- Pointers: wr_ptr and rd_ptr are AW+1 bits, AW = $clog2(DEPTH).
  - Address = low AW bits; level = wr_ptr - rd_ptr, modulo 2^(AW+1).
  - Wrap-around is natural binary rollover.
  - full = (level==DEPTH); empty = (level==0).
- Write: when s_axis_tvalid && s_axis_tready, store {tlast, tdata} at mem[wr_addr] and increment wr_ptr.
- Read: when m_axis_tvalid && m_axis_tready, increment rd_ptr.
  - m_axis_tdata/tlast = mem[rd_addr], read combinationally from the registered rd_ptr.
- Registered handshakes, computed from next-state occupancy nlevel = level + wr_fire - rd_fire:
  - s_axis_tready <= (nlevel != DEPTH).
  - m_axis_tvalid <= (nlevel != 0).
- Latency: a beat accepted in cycle N is visible on m_axis in cycle N+1 if the buffer was empty. There is no combinational path from s_axis to m_axis.
- Throughput: 1 beat/cycle sustained with simultaneous read and write at any level 1..DEPTH-1.
- At level DEPTH-1, a write without a read sets full, so s_axis_tready=0 next cycle. No beat is ever lost or duplicated.
- Full with a read: s_axis_tready=1 next cycle. A write is not accepted in the full cycle itself, because tready is low.
- Empty with a write: m_axis_tvalid=1 next cycle. A read cannot occur in the empty cycle.
- Flags are combinational from level; they update the cycle after the causing handshake.
- Flush (priority below rst, above all traffic):
  - Pointers go to 0, m_axis_tvalid <= 0, s_axis_tready <= 1.
  - Any handshake on either side in the flush cycle is discarded: the beat is not stored and rd_ptr does not advance. Upstream and downstream treat such a beat as transferred-and-dropped.
- Reset or flush mid-packet: no partial-packet recovery. The downstream packet framer is responsible.
- m_axis_tdata is undefined while m_axis_tvalid=0; the bench must not check it then.
- Stability: while m_axis_tvalid && !m_axis_tready, m_axis_tdata/tlast stay stable. Writes never target rd_addr when level>0 and not full.

Decomposition:
- Package stream_buf_pkg holds:
  - function ptr_w(depth) = $clog2(depth)+1;
  - typedef for the stored entry struct {logic last; logic [DWIDTH-1:0] data} (parametrised via a macro or a localparam in the module);
  - the elaboration-check helper is_pow2.
- Sub-module: ring_buf_mem, a DEPTH x (DWIDTH+1) register array with one synchronous write port and one asynchronous read port. Isolating it allows later swap to LUTRAM/BRAM.
- Control logic (pointers, handshakes, flags, flush) stays in axis_ring_buf.

Test Plan (DEPTH=4, DWIDTH=32, AFULL_THRESH=3, AEMPTY_THRESH=1):
- Reset, then idle:
  - Check m_axis_tvalid=0, s_axis_tready=1, level=0, almost_empty=1, almost_full=0.
- Fill with downstream stalled:
  - Write 0xA0..0xA3, m_axis_tready=0.
  - Expect level 1,2,3,4; almost_full from level 3; s_axis_tready=0 the cycle after the 4th accept.
  - A 5th beat 0xA4 is held, not accepted.
- Drain from full:
  - Release m_axis_tready=1.
  - Expect 0xA0..0xA3 in order; s_axis_tready=1 one cycle after the first read; 0xA4 accepted next.
  - m_axis_tvalid=0 after the last read.
- Streaming with wrap-around:
  - 20 beats, 0x00..0x13, tvalid/tready both 1.
  - Expect 1 beat/cycle after 1-cycle latency, level steady at 1, correct order across pointer wrap, tlast on beats 0x07 and 0x13 propagated.
- Random back-pressure:
  - 1000 beats, random tvalid/tready at 50%.
  - Scoreboard confirms no loss or duplication; level always equals accepted minus delivered; level never exceeds 4.
- Flush:
  - With level=3, assert flush together with a write (0xFF) and a read.
  - Expect level=0 and m_axis_tvalid=0 next cycle, s_axis_tready=1.
  - 0xFF never appears on output; the next write 0x55 is output first.
